mem_access_ctrl: RTL

- Memory-stage access controller; sits directly downstream of the store-data packer and the MEM pipeline stage.
- Takes one load/store per instruction: address, mem op, lane-aligned store data.
- Generates the byte write mask and runs a valid/ready request and response handshake with the data memory.
- Stalls the pipeline until the access completes, then returns raw 64-bit read data to the load-extract stage.

---
 rtl/mem_access_ctrl_pkg.sv | 27 ++
 rtl/mem_access_ctrl_if.sv | 26 ++
 rtl/mem_access_ctrl_mask_gen.sv | 35 +++
 rtl/mem_access_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared core types for the memory-stage access controller: data/address widths,
// memory op encoding, byte mask type and controller state encoding.
package CorePack;

  typedef logic [63:0] data_t;
  typedef logic [63:0] addr_t;
  typedef logic [7:0]  mask_t;

  typedef enum logic [2:0] {
    MEM_NO = 3'd0,
    MEM_B  = 3'd1,
    MEM_BU = 3'd2,
    MEM_H  = 3'd3,
    MEM_HU = 3'd4,
    MEM_W  = 3'd5,
    MEM_WU = 3'd6,
    MEM_D  = 3'd7
  } mem_op_enum;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } mem_ctrl_state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/response bus; master = access controller, slave = memory.
interface mem_access_ctrl_if;

  logic             mem_req_valid;
  logic             mem_req_ready;
  CorePack::addr_t  mem_req_addr;
  logic             mem_req_wen;
  CorePack::data_t  mem_req_wdata;
  CorePack::mask_t  mem_req_wmask;
  logic             mem_resp_valid;
  logic             mem_resp_ready;
  CorePack::data_t  mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output mem_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  mem_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

endinterface

// File: rtl/mem_access_ctrl_mask_gen.sv
// Byte-enable mask and misalignment detection from access size and low address bits.
module mem_mask_gen
  import CorePack::*;
(
  input  mem_op_enum  op,
  input  logic [2:0]  addr_lo,
  output mask_t       mask,
  output logic        misalign
);

  always_comb begin
    mask     = '0;
    misalign = 1'b0;
    unique case (op)
      MEM_B, MEM_BU: mask = 8'h01 << addr_lo;
      MEM_H, MEM_HU: begin
        mask     = 8'h03 << addr_lo;
        misalign = addr_lo[0];
      end
      MEM_W, MEM_WU: begin
        mask     = 8'h0F << addr_lo;
        misalign = |addr_lo[1:0];
      end
      MEM_D: begin
        mask     = 8'hFF;
        misalign = |addr_lo;
      end
      default: begin
        mask     = '0;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: latches one load/store, runs the request/response
// handshake and stalls the pipeline until done. Optional MEM_TIMEOUT_EN adds a response timeout.
module mem_access_ctrl
  import CorePack::*;
`ifdef MEM_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_valid,
  input  logic         cpu_we,
  input  mem_op_enum   cpu_op,
  input  addr_t        cpu_addr,
  input  data_t        cpu_wdata,
  output logic         cpu_stall,
  output logic         cpu_done,
  output data_t        cpu_rdata,
  output logic         cpu_misalign,
`ifdef MEM_TIMEOUT_EN
  output logic         cpu_timeout,
`endif
  mem_access_ctrl_if.master mem
);

  mem_ctrl_state_e state_q, state_d;

  logic [60:0] addr_hi_q;
  data_t       wdata_q;
  data_t       rdata_q;
  mask_t       mask_q;
  logic        we_q;
  logic        misalign_q;

  mask_t       gen_mask;
  logic        gen_misalign;
  logic        accept;
  logic        tmo_hit;

  mem_mask_gen u_mask_gen (
    .op       (cpu_op),
    .addr_lo  (cpu_addr[2:0]),
    .mask     (gen_mask),
    .misalign (gen_misalign)
  );

  assign accept = (state_q == IDLE) && cpu_valid && (cpu_op != MEM_NO);

`ifdef MEM_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        timeout_q;

  assign tmo_hit = (state_q == WAIT_RESP) && !mem.mem_resp_valid &&
                   (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept)
        timeout_q <= 1'b0;
      else if (tmo_hit)
        timeout_q <= 1'b1;
      // counter restarts whenever the request is handed off to the memory
      if (state_q == REQ && mem.mem_req_ready)
        tmo_cnt_q <= '0;
      else if (state_q == WAIT_RESP)
        tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  assign cpu_timeout = (state_q == DONE) && timeout_q;
`else
  assign tmo_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state and handshake outputs
  always_comb begin
    state_d            = state_q;
    cpu_stall          = 1'b0;
    cpu_done           = 1'b0;
    mem.mem_req_valid  = 1'b0;
    mem.mem_resp_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cpu_stall = 1'b1;
          state_d   = gen_misalign ? DONE : REQ;
        end
      end
      REQ: begin
        cpu_stall         = 1'b1;
        mem.mem_req_valid = 1'b1;
        if (mem.mem_req_ready) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        cpu_stall          = 1'b1;
        mem.mem_resp_ready = 1'b1;
        if (mem.mem_resp_valid || tmo_hit) state_d = DONE;
      end
      DONE: begin
        cpu_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // latched request fields and captured read data
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_hi_q  <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (accept) begin
        addr_hi_q  <= cpu_addr[63:3];
        wdata_q    <= cpu_wdata;
        mask_q     <= cpu_we ? gen_mask : 8'h00;
        we_q       <= cpu_we;
        misalign_q <= gen_misalign;
      end
      if (state_q == WAIT_RESP && mem.mem_resp_valid)
        rdata_q <= mem.mem_resp_rdata;
      else if (tmo_hit)
        rdata_q <= '0;
    end
  end

  assign mem.mem_req_addr  = {addr_hi_q, 3'b000};
  assign mem.mem_req_wen   = we_q;
  assign mem.mem_req_wdata = wdata_q;
  assign mem.mem_req_wmask = mask_q;

  assign cpu_rdata    = rdata_q;
  assign cpu_misalign = (state_q == DONE) && misalign_q;

endmodule
